ultrasonic_echo_responder: RTL and testbench
============================================

Name: ultrasonic_echo_responder

Overview:
- Synthesizable model of an HC-SR04-style ultrasonic sensor: the sensor end of the trig/echo interface.
- Accepts a trigger pulse from the range-finder controller.
- After a fixed acoustic-burst delay, drives an echo pulse whose width encodes a programmed target distance.
- Used for hardware-in-the-loop loopback on the 100 MHz board and as a bench model for the obstacle-detection logic.

Parameters:
- MIN_TRIG, 26'd1000: minimum valid trig high time in clocks (10 us).
- ECHO_DELAY, 26'd20000: clocks from accepted trig fall to echo rise (200 us burst).
- TIMEOUT, 26'd3800000: echo width when no obstacle, and the maximum echo width (38 ms).
- HOLDOFF, 26'd1000000: dead time after echo falls, during which trig is ignored (10 ms).

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- trig  in  1  trigger from controller; asynchronous to the responder, so it is 2-flop synchronized.
- obstacle  in  1  1 = target present, echo width = echo_width; 0 = no target, echo width = TIMEOUT.
- echo_width  in  26  programmed echo high time in clocks; sampled at trig acceptance.
- echo  out  1  echo pulse to controller.
- busy  out  1  high in any state other than IDLE.
- short_cnt  out  8  count of rejected short trig pulses, saturating at 255.

Behaviour:
- Reset is synchronous and active-high, on the posedge of CLK100MHZ, and wins over all other activity, including mid-echo. It sets:
  - echo=0, busy=0, short_cnt=0, state=IDLE, all counters 0;
  - both synchronizer flops and the edge-detect register to 0.
- trig_s is trig delayed by 2 flops. trig_rise = trig_s & ~trig_s_d.
- State IDLE:
  - echo=0.
  - On trig_rise: go to TRIG_HI with trig_cnt=1.
  - A level-high trig_s with no rise, e.g. held across HOLDOFF, never arms the block.
- State TRIG_HI:
  - While trig_s=1: trig_cnt increments, saturating at MIN_TRIG.
  - On trig_s=0 with trig_cnt>=MIN_TRIG: latch the width, set dly_cnt=0, go to DELAY.
    - Width = TIMEOUT if obstacle=0.
    - Otherwise width = echo_width clamped: 0 becomes 1, values above TIMEOUT become TIMEOUT.
    - obstacle and echo_width are sampled on this same edge.
  - On trig_s=0 with trig_cnt<MIN_TRIG: short_cnt increments (saturating at 255), go to IDLE. No echo is produced.
- State DELAY:
  - dly_cnt increments each cycle.
  - When dly_cnt==ECHO_DELAY-1: go to ECHO and set echo=1, with echo_cnt=0.
  - trig is ignored.
- State ECHO:
  - echo=1 for exactly the latched width in cycles.
  - When echo_cnt==width-1: echo=0, hold_cnt=0, go to HOLDOFF.
  - trig is ignored.
- State HOLDOFF:
  - echo=0; counts HOLDOFF cycles, then goes to IDLE.
  - trig is ignored, but the synchronizer and edge register keep updating.
- Latency:
  - Let t be the first edge at which raw trig is sampled low after a valid pulse.
  - echo is first high in the cycle after edge t+2+ECHO_DELAY.
  - From the raw trig fall to the echo rise is ECHO_DELAY+3 cycles, with ±0 jitter for a synchronous stimulus.
- Changes to echo_width or obstacle during DELAY, ECHO or HOLDOFF have no effect on the pulse in flight.
- Counter widths: 26 bits, no wrap. All terminal compares use ==; saturation applies where stated.
- Parameter constraints: ECHO_DELAY, HOLDOFF and TIMEOUT must each be >=1 and <2^26.

Test Plan:
- Bench parameters: MIN_TRIG=10, ECHO_DELAY=20, TIMEOUT=1000, HOLDOFF=50.
- Valid hit: trig high 12 cycles, obstacle=1, echo_width=300 -> echo rises exactly 23 cycles after the raw trig fall, stays high 300 cycles, busy drops 50 cycles after echo falls; short_cnt=0.
- No target: trig high 10 cycles, obstacle=0, echo_width=5 -> echo width 1000. Clamp: obstacle=1, echo_width=5000 -> width 1000; echo_width=0 -> width 1.
- Short trig: trig high 9 cycles -> no echo, busy low 1 cycle after the trig_s fall, short_cnt=1. Repeat 300 times -> short_cnt=255.
- Ignored re-trigger: valid pulse, then a second 12-cycle trig pulse during ECHO and a third during HOLDOFF -> exactly one echo. A trig held high from HOLDOFF into IDLE does not arm the block; the next clean rise is accepted.
- Reset mid-operation: assert reset for 1 cycle at echo_cnt=150 -> echo=0 and busy=0 on the next cycle, short_cnt=0; a subsequent valid trig gives a normal echo.
- Input stability: toggle echo_width 300->700 during DELAY -> echo width stays 300.

Source files
------------

// File: rtl/ultrasonic_echo_responder.sv
// Sensor end of an HC-SR04-style trig/echo link: validates a trigger pulse, waits the
// acoustic-burst delay, then drives an echo whose width encodes the programmed distance.
module ultrasonic_echo_responder #(
  parameter logic [25:0] MIN_TRIG   = 26'd1000,
  parameter logic [25:0] ECHO_DELAY = 26'd20000,
  parameter logic [25:0] TIMEOUT    = 26'd3800000,
  parameter logic [25:0] HOLDOFF    = 26'd1000000
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        trig,
  input  logic        obstacle,
  input  logic [25:0] echo_width,
  output logic        echo,
  output logic        busy,
  output logic [7:0]  short_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG_HI,
    ST_DELAY,
    ST_ECHO,
    ST_HOLDOFF
  } state_t;

  state_t      state, state_nxt;
  logic        trig_m, trig_s, trig_s_d;
  logic        trig_rise;
  logic [25:0] trig_cnt, dly_cnt, echo_cnt, hold_cnt;
  logic [25:0] width, width_sel;

  assign trig_rise = trig_s & ~trig_s_d;

  // Echo width chosen at acceptance: no target means full timeout, otherwise clamp to [1, TIMEOUT].
  always_comb begin
    width_sel = echo_width;
    if (!obstacle)
      width_sel = TIMEOUT;
    else if (echo_width == '0)
      width_sel = 26'd1;
    else if (echo_width > TIMEOUT)
      width_sel = TIMEOUT;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      trig_m    <= 1'b0;
      trig_s    <= 1'b0;
      trig_s_d  <= 1'b0;
      state     <= ST_IDLE;
      trig_cnt  <= '0;
      dly_cnt   <= '0;
      echo_cnt  <= '0;
      hold_cnt  <= '0;
      width     <= '0;
      short_cnt <= '0;
    end else begin
      trig_m   <= trig;
      trig_s   <= trig_m;
      trig_s_d <= trig_s;
      state    <= state_nxt;
      case (state)
        ST_IDLE:
          if (trig_rise) trig_cnt <= 26'd1;
        ST_TRIG_HI:
          if (trig_s) begin
            if (trig_cnt < MIN_TRIG) trig_cnt <= trig_cnt + 26'd1;
          end else if (trig_cnt >= MIN_TRIG) begin
            width   <= width_sel;
            dly_cnt <= '0;
          end else if (short_cnt != '1) begin
            short_cnt <= short_cnt + 8'd1;
          end
        ST_DELAY:
          if (dly_cnt == ECHO_DELAY - 26'd1) echo_cnt <= '0;
          else dly_cnt <= dly_cnt + 26'd1;
        ST_ECHO:
          if (echo_cnt == width - 26'd1) hold_cnt <= '0;
          else echo_cnt <= echo_cnt + 26'd1;
        ST_HOLDOFF:
          hold_cnt <= hold_cnt + 26'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (trig_rise) state_nxt = ST_TRIG_HI;
      ST_TRIG_HI: if (!trig_s) state_nxt = (trig_cnt >= MIN_TRIG) ? ST_DELAY : ST_IDLE;
      ST_DELAY:   if (dly_cnt == ECHO_DELAY - 26'd1) state_nxt = ST_ECHO;
      ST_ECHO:    if (echo_cnt == width - 26'd1) state_nxt = ST_HOLDOFF;
      ST_HOLDOFF: if (hold_cnt == HOLDOFF - 26'd1) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    echo = (state == ST_ECHO);
    busy = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Scoreboard bench: stimulus queues expected echo rise cycle and width, an independent
// monitor measures each echo pulse on the falling edge of the clock and compares.
module tb_ultrasonic_echo_responder;

  logic        CLK100MHZ = 1'b0;
  logic        reset = 1'b1;
  logic        trig = 1'b0;
  logic        obstacle = 1'b0;
  logic [25:0] echo_width = '0;
  logic        echo, busy;
  logic [7:0]  short_cnt;

  ultrasonic_echo_responder #(
    .MIN_TRIG  (26'd10),
    .ECHO_DELAY(26'd20),
    .TIMEOUT   (26'd1000),
    .HOLDOFF   (26'd50)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .trig      (trig),
    .obstacle  (obstacle),
    .echo_width(echo_width),
    .echo      (echo),
    .busy      (busy),
    .short_cnt (short_cnt)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int cyc = 0;
  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int exp_rise_q[$];
  int exp_width_q[$];
  bit abort_pending = 1'b0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: measures every echo pulse and compares with the oldest queued expectation.
  logic echo_prev = 1'b0;
  int   rise_cyc = 0;
  int   er, ew;
  always @(negedge CLK100MHZ) begin
    if (echo && !echo_prev) rise_cyc = cyc;
    if (!echo && echo_prev) begin
      if (exp_rise_q.size() == 0) begin
        check("unexpected_echo", 1, 0);
      end else begin
        er = exp_rise_q.pop_front();
        ew = exp_width_q.pop_front();
        if (abort_pending) abort_pending = 1'b0;
        else begin
          check("echo_rise_cycle", rise_cyc, er);
          check("echo_width", cyc - rise_cyc, ew);
        end
      end
    end
    echo_prev = echo;
  end

  task automatic tick(int n);
    repeat (n) @(posedge CLK100MHZ);
    #1;
  endtask

  // Called just after a posedge; raw trig is then sampled high on exactly n edges.
  task automatic pulse(int n, bit obst, int w, bit expect_echo, int exp_w);
    obstacle   = obst;
    echo_width = 26'(w);
    trig       = 1'b1;
    tick(n);
    trig = 1'b0;
    if (expect_echo) begin
      exp_rise_q.push_back(cyc + 23);
      exp_width_q.push_back(exp_w);
    end
  endtask

  task automatic wait_sig(bit use_busy, bit val, string name);
    int n = 0;
    @(negedge CLK100MHZ);
    while ((use_busy ? busy : echo) !== val && n < 5000) begin
      @(negedge CLK100MHZ);
      n++;
    end
    check(name, int'(use_busy ? busy : echo), int'(val));
  endtask

  int f;

  initial begin
    tick(3);
    check("reset_echo", int'(echo), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_short_cnt", int'(short_cnt), 0);
    reset = 1'b0;
    tick(2);

    // Valid hit with busy drop timing
    pulse(12, 1'b1, 300, 1'b1, 300);
    wait_sig(1'b0, 1'b1, "hit_echo_rise");
    wait_sig(1'b0, 1'b0, "hit_echo_fall");
    f = cyc;
    wait_sig(1'b1, 1'b0, "hit_idle");
    check("busy_after_echo", cyc - f, 50);
    check("hit_short_cnt", int'(short_cnt), 0);

    // No target, and clamp boundaries
    tick(1); pulse(10, 1'b0, 5, 1'b1, 1000);    wait_sig(1'b1, 1'b0, "notarget_idle");
    tick(1); pulse(12, 1'b1, 5000, 1'b1, 1000); wait_sig(1'b1, 1'b0, "clamp_hi_idle");
    tick(1); pulse(12, 1'b1, 0, 1'b1, 1);       wait_sig(1'b1, 1'b0, "clamp_lo_idle");

    // Inputs changed while the pulse is in flight
    tick(1); pulse(12, 1'b1, 300, 1'b1, 300);
    tick(5); echo_width = 26'd700;
    wait_sig(1'b1, 1'b0, "stable_idle");

    // Re-triggers during ECHO and HOLDOFF, then trig held high into IDLE
    tick(1); pulse(12, 1'b1, 300, 1'b1, 300);
    wait_sig(1'b0, 1'b1, "retrig_echo_rise");
    tick(1); pulse(12, 1'b1, 300, 1'b0, 0);
    wait_sig(1'b0, 1'b0, "retrig_echo_fall");
    tick(5); pulse(12, 1'b1, 300, 1'b0, 0);
    tick(3); trig = 1'b1;
    wait_sig(1'b1, 1'b0, "retrig_idle");
    tick(10);
    check("held_trig_no_arm", int'(busy), 0);
    trig = 1'b0;
    tick(3); pulse(12, 1'b1, 300, 1'b1, 300);
    wait_sig(1'b1, 1'b0, "clean_rise_idle");

    // Short trigger, then saturation
    tick(1); pulse(9, 1'b1, 300, 1'b0, 0);
    @(negedge CLK100MHZ); @(negedge CLK100MHZ); @(negedge CLK100MHZ);
    check("short_busy_before", int'(busy), 1);
    @(negedge CLK100MHZ);
    check("short_busy_after", int'(busy), 0);
    check("short_cnt_one", int'(short_cnt), 1);
    for (int i = 0; i < 299; i++) begin
      tick(1); pulse(9, 1'b1, 300, 1'b0, 0); tick(4);
    end
    tick(3);
    check("short_cnt_sat", int'(short_cnt), 255);
    check("short_busy_idle", int'(busy), 0);

    // Reset in the middle of an echo
    tick(1); pulse(12, 1'b1, 300, 1'b1, 300);
    wait_sig(1'b0, 1'b1, "rst_echo_rise");
    tick(150);
    abort_pending = 1'b1;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midrst_echo", int'(echo), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_short_cnt", int'(short_cnt), 0);
    tick(3); pulse(12, 1'b1, 300, 1'b1, 300);
    wait_sig(1'b1, 1'b0, "post_rst_idle");

    tick(5);
    check("scoreboard_empty", exp_rise_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
